// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/retire controller for the multi-cycle FPU beside Execute.
// Accepts one FPU op at a time, times its op-dependent latency, stalls the
// issue point on structural/RAW/WAW/writeback-port hazards and claims the
// shared writeback slot in the FPU retire cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   IssueValid          valid instruction at the issue point
//   IssueFPUOp          0/7 = ALU-only, 1..6 = FPU op
//   IssueRegWE          issuing ALU instruction writes a register
//   IssueRegWBAddr      destination of the issuing instruction
//   IssueSrcA/B         sources of the issuing instruction
//   Flush               issuing instruction squashed
//   HoldIn              downstream pipeline freeze
//   Stall               (comb) hold the issue point this cycle
//   FPUStart/StartOp    (comb) accept pulse and accepted opcode
//   FPUBusy             controller not idle
//   FPURetire           FPU result owns the writeback slot (WB mux select)
//   FPURetireAddr       destination of the op in flight
// Latencies must lie in 2..31 so that LAT-1 fits the 5-bit counter and is >= 1.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADD = 4,
    parameter int unsigned LAT_MUL = 6,
    parameter int unsigned LAT_DIV = 20,
    parameter int unsigned LAT_CVT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       IssueValid,
    input  logic [0:2] IssueFPUOp,
    input  logic       IssueRegWE,
    input  logic [0:5] IssueRegWBAddr,
    input  logic [0:5] IssueSrcA,
    input  logic [0:5] IssueSrcB,
    input  logic       Flush,
    input  logic       HoldIn,
    output logic       Stall,
    output logic       FPUStart,
    output logic [0:2] FPUStartOp,
    output logic       FPUBusy,
    output logic       FPURetire,
    output logic [0:5] FPURetireAddr
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ADDR_W = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_RETIRE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [0:ADDR_W-1]  pend_addr_q, pend_addr_d;

    logic issue;
    logic op_fpu;
    logic pend_nz;
    logic hit_a, hit_b, hit_wb;
    logic stall;
    logic accept;

    // Counter load value: latency minus one, since the accept cycle itself counts.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [0:OP_W-1] op);
        case (op)
            3'd1, 3'd2: lat_m1 = CNT_W'(LAT_ADD - 1);
            3'd3:       lat_m1 = CNT_W'(LAT_MUL - 1);
            3'd4:       lat_m1 = CNT_W'(LAT_DIV - 1);
            3'd5, 3'd6: lat_m1 = CNT_W'(LAT_CVT - 1);
            default:    lat_m1 = '0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Hazard detection, accept, next state and outputs
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pend_addr_d   = pend_addr_q;
        Stall         = 1'b0;
        FPUStart      = 1'b0;
        FPUStartOp    = '0;
        FPUBusy       = 1'b0;
        FPURetire     = 1'b0;
        FPURetireAddr = pend_addr_q;

        issue   = IssueValid & ~Flush;
        op_fpu  = (IssueFPUOp != OP_W'(0)) && (IssueFPUOp != OP_W'(7));
        // Register 0 is hardwired zero, so a pending r0 write never hazards.
        pend_nz = (pend_addr_q != ADDR_W'(0));
        hit_a   = pend_nz && (IssueSrcA == pend_addr_q);
        hit_b   = pend_nz && (IssueSrcB == pend_addr_q);
        hit_wb  = pend_nz && (IssueRegWBAddr == pend_addr_q);

        // No FPU forwarding path: RAW holds through the retire cycle too.
        stall = issue & (
                    ((state_q == S_RUN) & op_fpu) |
                    ((state_q != S_IDLE) & (hit_a | hit_b)) |
                    ((state_q == S_RUN) & IssueRegWE & hit_wb) |
                    ((state_q == S_RETIRE) & IssueRegWE & ~op_fpu));

        accept = issue & op_fpu & ~stall & ~HoldIn & (state_q != S_RUN) & ~reset;

        case (state_q)
            S_IDLE: ;
            // Count runs regardless of HoldIn; the result waits in RETIRE instead.
            S_RUN: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_RETIRE;
                end
            end
            S_RETIRE: begin
                if (!HoldIn) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept only happens outside RUN and never under HoldIn, so it overrides.
        if (accept) begin
            state_d     = S_RUN;
            count_d     = lat_m1(IssueFPUOp);
            pend_addr_d = IssueRegWBAddr;
        end

        Stall      = stall;
        FPUStart   = accept;
        FPUStartOp = accept ? IssueFPUOp : OP_W'(0);
        FPUBusy    = (state_q != S_IDLE);
        FPURetire  = (state_q == S_RETIRE);
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl (default latencies 4/6/20/3).
// Inputs change 1 time unit after the rising edge, outputs are sampled on the
// falling edge, so each vector describes one full clock cycle.
module tb_fpu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       IssueValid;
    logic [2:0] IssueFPUOp;
    logic       IssueRegWE;
    logic [5:0] IssueRegWBAddr;
    logic [5:0] IssueSrcA;
    logic [5:0] IssueSrcB;
    logic       Flush;
    logic       HoldIn;
    logic       Stall;
    logic       FPUStart;
    logic [2:0] FPUStartOp;
    logic       FPUBusy;
    logic       FPURetire;
    logic [5:0] FPURetireAddr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .IssueValid     (IssueValid),
        .IssueFPUOp     (IssueFPUOp),
        .IssueRegWE     (IssueRegWE),
        .IssueRegWBAddr (IssueRegWBAddr),
        .IssueSrcA      (IssueSrcA),
        .IssueSrcB      (IssueSrcB),
        .Flush          (Flush),
        .HoldIn         (HoldIn),
        .Stall          (Stall),
        .FPUStart       (FPUStart),
        .FPUStartOp     (FPUStartOp),
        .FPUBusy        (FPUBusy),
        .FPURetire      (FPURetire),
        .FPURetireAddr  (FPURetireAddr)
    );

    typedef struct {
        int v, op, we, wb, a, b, fl, hd;
        int st, sr, so, bz, rt, ra;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int v, int op, int we, int wb, int a, int b, int fl, int hd,
                                int st, int sr, int so, int bz, int rt, int ra);
        vec_t r;
        r.v = v; r.op = op; r.we = we; r.wb = wb; r.a = a; r.b = b; r.fl = fl; r.hd = hd;
        r.st = st; r.sr = sr; r.so = so; r.bz = bz; r.rt = rt; r.ra = ra;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input int op, input int we, input int wb,
                         input int a, input int b, input int fl, input int hd);
        IssueValid     = 1'(v);
        IssueFPUOp     = 3'(op);
        IssueRegWE     = 1'(we);
        IssueRegWBAddr = 6'(wb);
        IssueSrcA      = 6'(a);
        IssueSrcB      = 6'(b);
        Flush          = 1'(fl);
        HoldIn         = 1'(hd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic check_cycle(input string tag, input int st, input int sr, input int so,
                               input int bz, input int rt, input int ra);
        @(negedge clk);
        chk({tag, ".Stall"},         int'(Stall),         st);
        chk({tag, ".FPUStart"},      int'(FPUStart),      sr);
        chk({tag, ".FPUStartOp"},    int'(FPUStartOp),    so);
        chk({tag, ".FPUBusy"},       int'(FPUBusy),       bz);
        chk({tag, ".FPURetire"},     int'(FPURetire),     rt);
        chk({tag, ".FPURetireAddr"}, int'(FPURetireAddr), ra);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.Stall",         int'(Stall),         0);
        chk("rst.FPUStart",      int'(FPUStart),      0);
        chk("rst.FPUBusy",       int'(FPUBusy),       0);
        chk("rst.FPURetire",     int'(FPURetire),     0);
        chk("rst.FPURetireAddr", int'(FPURetireAddr), 0);
        reset = 1'b0;

        // Mul to r40, independent ALU traffic, retire only at T=6
        vecs.push_back(mk(1,3,0,40,1,2,0,0, 0,1,3,0,0,0));
        vecs.push_back(mk(1,0,1,5,1,2,0,0,  0,0,0,1,0,40));
        vecs.push_back(mk(1,0,1,6,3,4,0,0,  0,0,0,1,0,40));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,0,40));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,1,40));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,40));
        // Add to r33, RAW on SrcB stalls through the retire cycle
        vecs.push_back(mk(1,1,0,33,0,0,0,0, 0,1,1,0,0,40));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,0,33));
        vecs.push_back(mk(1,0,0,9,1,33,0,0, 1,0,0,1,0,33));
        vecs.push_back(mk(1,0,0,9,1,33,0,0, 1,0,0,1,0,33));
        vecs.push_back(mk(1,0,0,9,1,33,0,0, 1,0,0,1,1,33));
        vecs.push_back(mk(1,0,0,9,1,33,0,0, 0,0,0,0,0,33));
        // Add to r0: reading r0 never hazards
        vecs.push_back(mk(1,1,0,0,0,0,0,0,  0,1,1,0,0,33));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,9,1,0,0,0,  0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,9,1,0,0,0,  0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,9,1,0,0,0,  0,0,0,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,0));
        // Add to r10: WAW stalls, op 7 behaves as ALU, no-WE same dest is fine
        vecs.push_back(mk(1,1,0,10,0,0,0,0, 0,1,1,0,0,0));
        vecs.push_back(mk(1,0,1,10,1,2,0,0, 1,0,0,1,0,10));
        vecs.push_back(mk(1,7,0,10,1,2,0,0, 0,0,0,1,0,10));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,0,10));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,1,10));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,10));
        // Cvt to r12: writeback-port collision at T=3 only
        vecs.push_back(mk(1,5,0,12,0,0,0,0, 0,1,5,0,0,10));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,0,12));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,0,12));
        vecs.push_back(mk(1,0,1,7,1,2,0,0,  1,0,0,1,1,12));
        vecs.push_back(mk(1,0,1,7,1,2,0,0,  0,0,0,0,0,12));
        // Mul to r20 with HoldIn at T=6..7; flushed RAW never stalls
        vecs.push_back(mk(1,3,0,20,0,0,0,0, 0,1,3,0,0,12));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,0,20));
        vecs.push_back(mk(1,0,0,0,20,0,0,1, 1,0,0,1,1,20));
        vecs.push_back(mk(1,0,0,0,20,0,1,1, 0,0,0,1,1,20));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,1,1,20));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0,20));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].we, vecs[i].wb,
                  vecs[i].a, vecs[i].b, vecs[i].fl, vecs[i].hd);
            check_cycle($sformatf("vec%0d", i), vecs[i].st, vecs[i].sr, vecs[i].so,
                        vecs[i].bz, vecs[i].rt, vecs[i].ra);
        end

        // Div to r21, second FPU op (add to r22) stalls until the retire cycle
        drive(1, 4, 0, 21, 0, 0, 0, 0);
        check_cycle("div.T0", 0, 1, 4, 0, 0, 20);
        idle();
        check_cycle("div.T1", 0, 0, 0, 1, 0, 21);
        check_cycle("div.T2", 0, 0, 0, 1, 0, 21);
        for (int t = 3; t < 20; t++) begin
            drive(1, 1, 0, 22, 0, 0, 0, 0);
            check_cycle($sformatf("div.T%0d", t), 1, 0, 0, 1, 0, 21);
        end
        drive(1, 1, 0, 22, 0, 0, 0, 0);
        check_cycle("div.T20", 0, 1, 1, 1, 1, 21);
        idle();
        for (int t = 21; t < 24; t++) check_cycle($sformatf("div.T%0d", t), 0, 0, 0, 1, 0, 22);
        check_cycle("div.T24", 0, 0, 0, 1, 1, 22);
        check_cycle("div.T25", 0, 0, 0, 0, 0, 22);

        // Reset mid-RUN drops the op; a later add retires normally
        drive(1, 4, 0, 21, 0, 0, 0, 0);
        check_cycle("rmr.T0", 0, 1, 4, 0, 0, 22);
        idle();
        for (int t = 1; t < 5; t++) check_cycle($sformatf("rmr.T%0d", t), 0, 0, 0, 1, 0, 21);
        reset = 1'b1;
        #1;
        chk("rmr.T5.FPUBusy",       int'(FPUBusy),       0);
        chk("rmr.T5.FPURetire",     int'(FPURetire),     0);
        chk("rmr.T5.FPURetireAddr", int'(FPURetireAddr), 0);
        chk("rmr.T5.Stall",         int'(Stall),         0);
        chk("rmr.T5.FPUStart",      int'(FPUStart),      0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_cycle("rmr.T6", 0, 0, 0, 0, 0, 0);
        check_cycle("rmr.T7", 0, 0, 0, 0, 0, 0);
        drive(1, 2, 0, 30, 0, 0, 0, 0);
        check_cycle("rmr.T8", 0, 1, 2, 0, 0, 0);
        idle();
        for (int t = 9; t < 12; t++) check_cycle($sformatf("rmr.T%0d", t), 0, 0, 0, 1, 0, 30);
        check_cycle("rmr.T12", 0, 0, 0, 1, 1, 30);
        for (int t = 13; t < 26; t++) check_cycle($sformatf("rmr.T%0d", t), 0, 0, 0, 0, 0, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
